// File: rtl/uart_tx_arbiter.sv
// ============================================================================
// Module      : uart_tx_arbiter
// Description : Round-robin sharing of one async_transmitter among N_REQ byte
//               producers, with a busy-timeout. Optional per-requester lock
//               enabled by defining UART_TX_ARB_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_arbiter #(
    parameter int N_REQ    = 4,
    parameter int DATA_W   = 8,
    parameter int BUSY_TO  = 16
`ifdef UART_TX_ARB_LOCK_EN
   ,parameter int MAX_LOCK = 16
`endif
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
`ifdef UART_TX_ARB_LOCK_EN
    input  logic [N_REQ-1:0]          lock,
`endif
    output logic [N_REQ-1:0]          ack,
    output logic [N_REQ-1:0]          grant,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    input  logic                      tx_busy,
    output logic                      err
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(BUSY_TO + 1);

    localparam logic [1:0] S_IDLE      = 2'd0;
    localparam logic [1:0] S_START     = 2'd1;
    localparam logic [1:0] S_WAIT_BUSY = 2'd2;
    localparam logic [1:0] S_WAIT_DONE = 2'd3;

    logic [1:0]        state;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  gidx;
    logic [CNT_W-1:0]  to_cnt;

    logic              rr_found;
    logic [IDX_W-1:0]  rr_idx;
    logic [IDX_W:0]    rr_sum;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W-1:0]  ptr_next;
    logic [DATA_W-1:0] sel_data;

    // First requester at or after ptr, wrapping modulo N_REQ
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        rr_sum   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            rr_sum = {1'b0, ptr} + (IDX_W+1)'(k);
            if (rr_sum >= (IDX_W+1)'(N_REQ))
                rr_sum = rr_sum - (IDX_W+1)'(N_REQ);
            if (!rr_found && req[rr_sum[IDX_W-1:0]]) begin
                rr_found = 1'b1;
                rr_idx   = rr_sum[IDX_W-1:0];
            end
        end
    end

`ifdef UART_TX_ARB_LOCK_EN
    localparam int LOCK_W = $clog2(MAX_LOCK + 1);

    logic              lock_pend;
    logic [LOCK_W-1:0] lock_cnt;
    logic              lock_hit;

    // Locked owner keeps priority until it has sent MAX_LOCK consecutive bytes
    assign lock_hit = lock_pend && req[gidx] && (lock_cnt < LOCK_W'(MAX_LOCK));
    assign win_idx  = lock_hit ? gidx : rr_idx;
`else
    assign win_idx  = rr_idx;
`endif

    assign ptr_next = (win_idx == IDX_W'(N_REQ - 1)) ? '0 : win_idx + 1'b1;

    always_comb begin
        sel_data = '0;
        for (int k = 0; k < N_REQ; k++) begin
            if (win_idx == IDX_W'(k))
                sel_data = req_data[k*DATA_W +: DATA_W];
        end
    end

    assign tx_start = (state == S_START);
    assign ack      = tx_start ? grant : '0;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            gidx      <= '0;
            to_cnt    <= '0;
            grant     <= '0;
            tx_data   <= '0;
            err       <= 1'b0;
`ifdef UART_TX_ARB_LOCK_EN
            lock_pend <= 1'b0;
            lock_cnt  <= '0;
`endif
        end else begin
            err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (rr_found && !tx_busy) begin
                        state   <= S_START;
                        grant   <= N_REQ'(1) << win_idx;
                        gidx    <= win_idx;
                        tx_data <= sel_data;
`ifdef UART_TX_ARB_LOCK_EN
                        lock_pend <= 1'b0;
                        if (lock_hit) begin
                            lock_cnt <= lock_cnt + 1'b1;
                        end else begin
                            lock_cnt <= LOCK_W'(1);
                            ptr      <= ptr_next;
                        end
`else
                        ptr     <= ptr_next;
`endif
                    end
                end
                S_START: begin
                    state  <= S_WAIT_BUSY;
                    to_cnt <= '0;
                end
                S_WAIT_BUSY: begin
                    if (tx_busy) begin
                        state <= S_WAIT_DONE;
                    end else if (to_cnt == CNT_W'(BUSY_TO - 1)) begin
                        // Byte is dropped; ptr already moved past this requester
                        err   <= 1'b1;
                        grant <= '0;
                        state <= S_IDLE;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                S_WAIT_DONE: begin
                    if (!tx_busy) begin
                        grant <= '0;
                        state <= S_IDLE;
`ifdef UART_TX_ARB_LOCK_EN
                        lock_pend <= lock[gidx];
`endif
                    end
                end
                default: begin
                    state <= S_IDLE;
                    grant <= '0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_tx_arbiter.sv
// ============================================================================
// Module      : tb_uart_tx_arbiter
// Description : Directed self-checking bench for uart_tx_arbiter with a simple
//               transmitter model. Lock test built when UART_TX_ARB_LOCK_EN set.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_uart_tx_arbiter;

    localparam int HOLD = 40;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy = 1'b0;
    logic        err;
`ifdef UART_TX_ARB_LOCK_EN
    logic [3:0]  lock;
`endif

    int          checks = 0;
    int          errors = 0;
    logic        model_en;
    int          phase = 0;
    int          hold = 0;
    logic [7:0]  sent_q[$];
    int          ack_cnt = 0;
    int          ack_bad = 0;

    uart_tx_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
`ifdef UART_TX_ARB_LOCK_EN
        .lock     (lock),
`endif
        .ack      (ack),
        .grant    (grant),
        .tx_start (tx_start),
        .tx_data  (tx_data),
        .tx_busy  (tx_busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    // Transmitter model: busy rises two edges after start, held HOLD cycles
    always @(posedge clk) begin
        if (tx_start) sent_q.push_back(tx_data);
        if (ack != 4'b0000) begin
            ack_cnt++;
            if (!$onehot(ack) || ack !== grant) ack_bad++;
        end
        if (!model_en) begin
            tx_busy <= 1'b0;
            phase   <= 0;
        end else if (phase == 0) begin
            if (tx_start) phase <= 1;
        end else if (phase == 1) begin
            tx_busy <= 1'b1;
            hold    <= HOLD;
            phase   <= 2;
        end else begin
            if (hold <= 1) begin
                tx_busy <= 1'b0;
                phase   <= 0;
            end else begin
                hold <= hold - 1;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b0; req = '0; req_data = '0; model_en = 1'b1;
`ifdef UART_TX_ARB_LOCK_EN
        lock = '0;
`endif
        repeat (3) @(negedge clk);
        chk("rst_grant", grant, 0);
        chk("rst_start", tx_start, 0);
        chk("rst_ack", ack, 0);
        chk("rst_err", err, 0);
        chk("rst_data", tx_data, 0);
        rst = 1'b1;

        // Single request
        @(negedge clk); req = 4'b0001; req_data = 32'h0000_00A5;
        @(negedge clk);
        chk("t1_start", tx_start, 1);
        chk("t1_ack", ack, 4'b0001);
        chk("t1_grant", grant, 4'b0001);
        chk("t1_data", tx_data, 8'hA5);
        req = '0;
        @(negedge clk);
        chk("t1_start_pulse", tx_start, 0);
        chk("t1_ack_pulse", ack, 0);
        for (int i = 0; i < 50 && tx_busy !== 1'b1; i++) @(negedge clk);
        repeat (5) @(negedge clk);
        chk("t1_grant_busy", grant, 4'b0001);
        for (int i = 0; i < 200 && grant !== 4'b0000; i++) @(negedge clk);
        chk("t1_release", grant, 0);
        chk("t1_data_hold", tx_data, 8'hA5);

        // Fairness from ptr=0
        rst = 1'b0; repeat (2) @(negedge clk); rst = 1'b1;
        sent_q.delete(); ack_cnt = 0;
        req = 4'b1111; req_data = 32'h4332_2110;
        for (int i = 0; i < 2000 && sent_q.size() < 5; i++) @(negedge clk);
        req = '0;
        chk("fair_count", sent_q.size(), 5);
        chk("fair_b0", sent_q[0], 8'h10);
        chk("fair_b1", sent_q[1], 8'h21);
        chk("fair_b2", sent_q[2], 8'h32);
        chk("fair_b3", sent_q[3], 8'h43);
        chk("fair_b4", sent_q[4], 8'h10);
        for (int i = 0; i < 200 && grant !== 4'b0000; i++) @(negedge clk);
        chk("fair_acks", ack_cnt, 5);

        // Pointer: grant 2 then 0101 searches 3,0
        req = 4'b0100; req_data = 32'h0077_0066;
        for (int i = 0; i < 200 && tx_start !== 1'b1; i++) @(negedge clk);
        chk("ptr_g2", grant, 4'b0100);
        chk("ptr_d2", tx_data, 8'h77);
        req = 4'b0101;
        @(negedge clk);
        for (int i = 0; i < 200 && tx_start !== 1'b1; i++) @(negedge clk);
        chk("ptr_g0", grant, 4'b0001);
        chk("ptr_d0", tx_data, 8'h66);
        req = '0;
        for (int i = 0; i < 200 && grant !== 4'b0000; i++) @(negedge clk);
        chk("ptr_idle", grant, 0);

        // Busy timeout
        model_en = 1'b0;
        @(negedge clk); req = 4'b0010; req_data = 32'h0000_9900;
        @(negedge clk);
        chk("to_start", tx_start, 1);
        chk("to_grant", grant, 4'b0010);
        req = '0;
        repeat (16) @(negedge clk);
        chk("to_err_early", err, 0);
        chk("to_grant_hold", grant, 4'b0010);
        @(negedge clk);
        chk("to_err", err, 1);
        chk("to_grant_clr", grant, 0);
        req = 4'b0010; req_data = 32'h0000_9A00;
        @(negedge clk);
        chk("to_err_pulse", err, 0);
        chk("to_rearb", tx_start, 1);
        chk("to_rearb_data", tx_data, 8'h9A);
        req = '0;
        for (int i = 0; i < 40 && grant !== 4'b0000; i++) @(negedge clk);
        chk("to_idle2", grant, 0);
        model_en = 1'b1;
        @(negedge clk);

        // Reset during WAIT_DONE, then wait for busy to fall
        req = 4'b0001; req_data = 32'h0000_00C3;
        for (int i = 0; i < 200 && tx_start !== 1'b1; i++) @(negedge clk);
        req = '0;
        for (int i = 0; i < 50 && tx_busy !== 1'b1; i++) @(negedge clk);
        repeat (3) @(negedge clk);
        chk("mr_pre", grant, 4'b0001);
        rst = 1'b0;
        #1;
        chk("mr_grant", grant, 0);
        chk("mr_start", tx_start, 0);
        chk("mr_ack", ack, 0);
        chk("mr_err", err, 0);
        @(negedge clk);
        rst = 1'b1; req = 4'b0010; req_data = 32'h0000_3C00;
        repeat (5) @(negedge clk);
        chk("mr_busy_block", grant, 0);
        for (int i = 0; i < 200 && tx_busy !== 1'b0; i++) @(negedge clk);
        for (int i = 0; i < 20 && tx_start !== 1'b1; i++) @(negedge clk);
        chk("mr_grant_after", grant, 4'b0010);
        chk("mr_data_after", tx_data, 8'h3C);
        req = '0;
        for (int i = 0; i < 200 && grant !== 4'b0000; i++) @(negedge clk);

`ifdef UART_TX_ARB_LOCK_EN
        rst = 1'b0; repeat (2) @(negedge clk); rst = 1'b1;
        sent_q.delete();
        lock = 4'b0001; req = 4'b0011; req_data = 32'h0000_B1A0;
        for (int i = 0; i < 3000 && sent_q.size() < 18; i++) @(negedge clk);
        req = '0;
        chk("lk_count", (sent_q.size() >= 18) ? 1 : 0, 1);
        for (int k = 0; k < 16; k++) chk("lk_owner", sent_q[k], 8'hA0);
        chk("lk_other", sent_q[16], 8'hB1);
        chk("lk_resume", sent_q[17], 8'hA0);
        for (int i = 0; i < 200 && grant !== 4'b0000; i++) @(negedge clk);
`endif

        chk("ack_onehot", ack_bad, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one async_transmitter (start / data[7:0] / TxD_busy) among N_REQ byte producers in LAB1_top, e.g. receiver echo path, status reporter and debug dump.
- Round-robin arbitration with a per-byte request/ack handshake. Sequences the transmitter's start pulse and tracks its busy window.
- A busy-timeout detects a transmitter that never responds.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width.
- BUSY_TO, 16, clocks allowed between tx_start and tx_busy rising.
- MAX_LOCK, 16, maximum consecutive bytes under lock (optional feature only).

Ports:
- clk  in  1  system clock, 25 MHz on board.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  per-requester byte request, level.
- req_data  in  N_REQ*DATA_W  byte for requester i in slice [i*DATA_W +: DATA_W]; stable while req[i]=1 until ack[i].
- ack  out  N_REQ  one-cycle pulse: byte of requester i accepted.
- grant  out  N_REQ  one-hot owner of the transmitter; 0 when idle.
- tx_start  out  1  one-cycle start pulse to async_transmitter.
- tx_data  out  DATA_W  registered byte to async_transmitter.
- tx_busy  in  1  TxD_busy from async_transmitter.
- err  out  1  one-cycle pulse on busy-timeout.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE; ptr=0.
  - ack, grant, tx_start, tx_data, err all 0.
  - Reset mid-transfer aborts immediately; the transmitter's own frame is not controlled.
- States: IDLE, START, WAIT_BUSY, WAIT_DONE.
- IDLE:
  - Arbitrates only when (|req) and tx_busy=0.
  - Winner g = first i with req[i]=1, searching ptr, ptr+1, ... mod N_REQ.
  - At that edge: grant=onehot(g), tx_data=req_data slice g, ptr=(g+1) mod N_REQ, state→START.
- START (exactly 1 cycle):
  - tx_start=1 and ack[g]=1.
  - Next edge: state→WAIT_BUSY, timeout counter cleared.
  - Latency: req sampled at edge k → tx_start/ack high in cycle k..k+1.
- WAIT_BUSY:
  - tx_busy=1 → WAIT_DONE.
  - Counter reaching BUSY_TO with tx_busy still 0 → err=1 for one cycle, grant=0, state→IDLE. The byte is lost and not retried; ptr keeps its advanced value.
- WAIT_DONE:
  - tx_busy=0 → grant=0, state→IDLE.
  - Earliest re-arbitration is the next edge, so a minimum of one idle cycle separates transfers.
- tx_data holds its value until the next grant.
- ack is never asserted for a non-granted requester; at most one ack bit is high.
- req[i] dropped before grant: no effect. req[g] held after ack: treated as a new byte request at the next arbitration, subject to round-robin.
- tx_busy=1 while IDLE (e.g. after reset): no grant until it falls.
- Simultaneous requests: winner strictly by ptr order; no requester waits more than N_REQ-1 transfers.

Optional Feature:
- Macro UART_TX_ARB_LOCK_EN.
- Defined:
  - Adds input lock [N_REQ-1:0]. If lock[g]=1 when WAIT_DONE exits, the next arbitration gives g top priority if req[g]=1, and ptr is not advanced.
  - A lock counter limits this to MAX_LOCK consecutive bytes. After that, normal round-robin from g+1 for one arbitration, then the counter clears.
  - If req[g]=0, normal round-robin applies.
- Undefined: no lock port; pure round-robin.

Test Plan:
- Single request: after reset release, req=4'b0001 with data 8'hA5 and a transmitter model (busy 2 cycles after start, held 4320 cycles = 10 bits × 432) → tx_start and ack[0] high one cycle after req sampled; tx_data=8'hA5; grant=4'b0001 until busy falls.
- Fairness: req=4'b1111 held, data 8'h10/8'h21/8'h32/8'h43 → transmit order 8'h10, 8'h21, 8'h32, 8'h43, then 8'h10 again; exactly one ack per byte.
- Pointer: after granting 2, req=4'b0101 → requester 0 granted next (search 3, 0).
- Timeout: tx_busy tied 0, req=4'b0010 → err pulse 16 cycles after WAIT_BUSY entry, grant→0, IDLE, then a new arbitration.
- Reset mid-transfer: rst=0 during WAIT_DONE → grant, tx_start, ack, err=0 immediately; after release with tx_busy still 1, no grant until busy falls.
- UART_TX_ARB_LOCK_EN, lock=4'b0001, req=4'b0011 → 16 bytes from requester 0, then one from requester 1, then requester 0 resumes.
